fetch_unit: RTL and testbench

//  Producer end of the decode interface. It owns the PC, fetches instruction words over the

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/mux_types_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 28 ++
 rtl/next_pc_calc.sv | 35 +++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, fetch FSM states, PC increment.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALTED
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/mux_types_pkg.sv
// Datapath mux select encodings shared between decode and fetch.
// Latency: n/a (types only).
// Backpressure: n/a.
package mux_types_pkg;
  typedef enum logic [1:0] {
    PC_NXT,
    PC_BR,
    PC_J,
    PC_JR
  } pcMux;
endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of fetch_unit signals; pairs with decode on ins, pcSel, bf, immJ26, halt.
// Latency: n/a (wiring only).
// Backpressure: icache via ihit, decode/datapath via advance.
interface fetch_unit_if;
  import cpu_types_pkg::*;
  import mux_types_pkg::*;

  logic        ihit;
  word_t       imemload;
  logic        iREN;
  word_t       imemaddr;
  word_t       ins;
  logic        ins_valid;
  pcMux        pcSel;
  logic        bf;
  logic [25:0] immJ26;
  logic        halt;
  word_t       rdat1;
  logic        advance;
  word_t       pc;
  word_t       npc;
  logic        halted;

  modport fu (
    input  ihit, imemload, pcSel, bf, immJ26, halt, rdat1, advance,
    output iREN, imemaddr, ins, ins_valid, pc, npc, halted
  );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational successor-PC selection from decode controls.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is consumed only when fetch_unit retires.
module next_pc_calc
  import cpu_types_pkg::*;
  import mux_types_pkg::*;
(
  input  word_t       pc,
  input  word_t       ins,
  input  pcMux        pcSel,
  input  logic        bf,
  input  logic [25:0] immJ26,
  input  word_t       rdat1,
  output word_t       next_pc
);
  word_t       npc;
  word_t       br_off;
  logic [15:0] unused_ins_hi;

  assign npc           = pc + PC_STEP;
  assign br_off        = {{14{ins[15]}}, ins[15:0], 2'b00};
  assign unused_ins_hi = ins[31:16];

  // Pick the successor PC; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc = npc;
    case (pcSel)
      PC_NXT:  next_pc = npc;
      PC_BR:   next_pc = bf ? (npc + br_off) : npc;
      PC_J:    next_pc = {npc[31:28], immJ26, 2'b00};
      PC_JR:   next_pc = rdat1;
      default: next_pc = npc;
    endcase
  end
endmodule

// File: rtl/fetch_unit.sv
// PC owner: fetches over icache handshake, holds one instruction for decode.
// Latency: >=1 FETCH cycle (until ihit) + >=1 EXEC cycle (until advance/halt).
// Backpressure: waits in FETCH for ihit, in EXEC for advance; optional stats under FETCH_STATS_EN.
module fetch_unit
  import cpu_types_pkg::*;
  import mux_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  word_t            imemload,
  output logic             iREN,
  output word_t            imemaddr,
  output word_t            ins,
  output logic             ins_valid,
  input  pcMux             pcSel,
  input  logic             bf,
  input  logic [25:0]      immJ26,
  input  logic             halt,
  input  word_t            rdat1,
  input  logic             advance,
  output word_t            pc,
  output word_t            npc,
`ifdef FETCH_STATS_EN
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             halted
);
  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        ins_q, ins_d;
  word_t        next_pc;

  next_pc_calc u_next_pc (
    .pc      (pc_q),
    .ins     (ins_q),
    .pcSel   (pcSel),
    .bf      (bf),
    .immJ26  (immJ26),
    .rdat1   (rdat1),
    .next_pc (next_pc)
  );

  // State, PC and held instruction; reset aborts any in-flight fetch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  // Next-state logic: ihit only matters in FETCH, advance/halt only in EXEC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (ihit) begin
          ins_d   = imemload;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (halt) begin
          state_d = HALTED;
        end else if (advance) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  assign iREN      = (state_q == FETCH);
  assign imemaddr  = pc_q;
  assign ins       = ins_q;
  assign ins_valid = (state_q == EXEC);
  assign halted    = (state_q == HALTED);
  assign pc        = pc_q;
  assign npc       = pc_q + PC_STEP;

`ifdef FETCH_STATS_EN
  logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q;

  // Saturating fetch/stall counters; they only move in FETCH, so HALTED freezes them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == FETCH) begin
      if (ihit && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (!ihit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_types_pkg::*;
  import mux_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  word_t       imemload = '0;
  logic        iREN;
  word_t       imemaddr;
  word_t       ins;
  logic        ins_valid;
  pcMux        pcSel = PC_NXT;
  logic        bf = 1'b0;
  logic [25:0] immJ26 = '0;
  logic        halt = 1'b0;
  word_t       rdat1 = '0;
  logic        advance = 1'b0;
  word_t       pc;
  word_t       npc;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC, held instruction, stats counts.
  word_t m_pc, m_ins;
  int    m_fetch, m_stall;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .ins(ins), .ins_valid(ins_valid), .pcSel(pcSel),
    .bf(bf), .immJ26(immJ26), .halt(halt), .rdat1(rdat1), .advance(advance),
    .pc(pc), .npc(npc),
`ifdef FETCH_STATS_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural successor PC written from the ISA rules.
  function automatic word_t model_next(input pcMux sel, input logic b, input logic [25:0] imm,
                                       input word_t r, input word_t cur, input word_t iw);
    word_t n;
    int    off;
    n   = cur + 32'd4;
    off = int'($signed(iw[15:0]));
    case (sel)
      PC_BR:   return b ? n + word_t'(off * 4) : n;
      PC_J:    return (n & 32'hF000_0000) | (word_t'(imm) * 32'd4);
      PC_JR:   return r;
      default: return n;
    endcase
  endfunction

  // Hold reset for two cycles, check reset outputs, release; DUT is in FETCH on return.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; ihit = 1'b0; advance = 1'b0; halt = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_insv", 32'(ins_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ins", ins, 32'h0);
    RST = 1'b0;
    m_pc = 32'h0; m_ins = 32'h0; m_fetch = 0; m_stall = 0;
    @(negedge CLK);
  endtask

  // Starting at a negedge in FETCH: stall, then deliver word; returns at negedge in EXEC.
  task automatic fetch_instr(input int stalls, input word_t word);
    for (int i = 0; i < stalls; i++) begin
      chk("fetch_iren", 32'(iREN), 32'd1);
      chk("fetch_addr", imemaddr, m_pc);
      ihit = 1'b0; imemload = $urandom;
      advance = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      @(negedge CLK);
      m_stall++;
    end
    chk("fetch_addr", imemaddr, m_pc);
    ihit = 1'b1; imemload = word; advance = 1'b0; halt = 1'b0;
    @(negedge CLK);
    m_fetch++;
    m_ins = word;
    ihit = 1'b0;
    chk("exec_insv", 32'(ins_valid), 32'd1);
    chk("exec_ins", ins, m_ins);
    chk("exec_iren", 32'(iREN), 32'd0);
    chk("exec_pc", pc, m_pc);
  endtask

  // Starting at a negedge in EXEC: idle waits, then advance (optionally with halt).
  task automatic exec_instr(input pcMux sel, input logic b, input logic [25:0] imm,
                            input word_t r, input logic hlt, input int waits);
    pcSel = sel; bf = b; immJ26 = imm; rdat1 = r;
    for (int i = 0; i < waits; i++) begin
      ihit = 1'($urandom_range(0, 1)); imemload = $urandom;
      @(negedge CLK);
      ihit = 1'b0;
      chk("wait_ins", ins, m_ins);
      chk("wait_pc", pc, m_pc);
      chk("wait_insv", 32'(ins_valid), 32'd1);
    end
    chk("exec_npc", npc, m_pc + 32'd4);
    advance = 1'b1; halt = hlt;
    @(negedge CLK);
    advance = 1'b0; halt = 1'b0;
    if (!hlt) begin
      m_pc = model_next(sel, b, imm, r, m_pc, m_ins);
      chk("adv_pc", pc, m_pc);
      chk("adv_iren", 32'(iREN), 32'd1);
      chk("adv_addr", imemaddr, m_pc);
    end
  endtask

  task automatic jump_to(input word_t target);
    fetch_instr(0, $urandom);
    exec_instr(PC_JR, 1'b0, '0, target, 1'b0, 0);
  endtask

  initial begin
    do_reset();

    // First fetch: ihit on the third FETCH cycle.
    fetch_instr(2, 32'h2001_0005);
    chk("t1_addr", imemaddr, 32'h0);
    exec_instr(PC_NXT, 1'b0, '0, '0, 1'b0, 1);
    chk("t1_pc", pc, 32'h4);

    // Backward branch taken / not taken from 0x40.
    jump_to(32'h40);
    fetch_instr(1, 32'h1234_FFFE);
    exec_instr(PC_BR, 1'b1, '0, '0, 1'b0, 0);
    chk("t2_br_taken", pc, 32'h3C);
    jump_to(32'h40);
    fetch_instr(0, 32'h1234_FFFE);
    exec_instr(PC_BR, 1'b0, '0, '0, 1'b0, 2);
    chk("t2_br_not", pc, 32'h44);

    // Jump within region and register jump.
    jump_to(32'h1000_0000);
    fetch_instr(0, $urandom);
    exec_instr(PC_J, 1'b0, 26'h000_0010, '0, 1'b0, 0);
    chk("t3_j", pc, 32'h1000_0040);
    fetch_instr(0, $urandom);
    exec_instr(PC_JR, 1'b0, '0, 32'h0000_0200, 1'b0, 0);
    chk("t3_jr", pc, 32'h200);

    // Sequential wrap at the top of the address space.
    jump_to(32'hFFFF_FFFC);
    fetch_instr(0, $urandom);
    exec_instr(PC_NXT, 1'b0, '0, '0, 1'b0, 0);
    chk("wrap_pc", pc, 32'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      fetch_instr($urandom_range(0, 3), $urandom);
      exec_instr(pcMux'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 26'($urandom), $urandom, 1'b0, $urandom_range(0, 2));
    end

    // Reset mid-FETCH with ihit high must not capture imemload.
    fetch_instr(0, 32'hCAFE_0001);
    exec_instr(PC_NXT, 1'b0, '0, '0, 1'b0, 0);
    RST = 1'b1; ihit = 1'b1; imemload = 32'hDEAD_BEEF;
    #1;
    chk("t5_pc_async", pc, 32'h0);
    @(negedge CLK);
    chk("t5_ins", ins, 32'h0);
    chk("t5_halted", 32'(halted), 32'd0);
    chk("t5_insv", 32'(ins_valid), 32'd0);
    ihit = 1'b0;
    do_reset();

`ifdef FETCH_STATS_EN
    for (int n = 0; n < 3; n++) begin
      fetch_instr(2, $urandom);
      exec_instr(PC_NXT, 1'b0, '0, '0, 1'b0, 0);
    end
    chk("t6_fetch_cnt", fetch_cnt, 32'(m_fetch));
    chk("t6_stall_cnt", stall_cnt, 32'(m_stall));
    chk("t6_fetch3", fetch_cnt, 32'd3);
    chk("t6_stall6", stall_cnt, 32'd6);
`endif

    // Halt and advance together: halt wins, state sticks.
    fetch_instr(1, $urandom);
    exec_instr(PC_NXT, 1'b0, '0, '0, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_halted", 32'(halted), 32'd1);
      chk("t4_pc", pc, m_pc);
      chk("t4_iren", 32'(iREN), 32'd0);
      chk("t4_insv", 32'(ins_valid), 32'd0);
`ifdef FETCH_STATS_EN
      chk("t4_fetch_frz", fetch_cnt, 32'(m_fetch));
      chk("t4_stall_frz", stall_cnt, 32'(m_stall));
`endif
      ihit = 1'($urandom_range(0, 1)); advance = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    ihit = 1'b0; advance = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
